// File: rtl/game_pkg.sv
// Shared types and helpers for the Minesweeper game-status tracker.
// The state enum is also the encoding driven on the 2-bit state output.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAYING = 2'd1,
        LOST    = 2'd2,
        WON     = 2'd3
    } game_state_e;

    localparam int MINE_CODE_DEF = 9;

    // Bits needed to hold values 0..value-1, never less than 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/game_status_fsm_if.sv
// Reveal handshake between the click controller (master) and the status tracker (slave).
interface game_status_fsm_if #(
    parameter int IDX_W  = 6,
    parameter int CELL_W = 4
);
    logic              reveal_valid;
    logic              reveal_ready;
    logic [IDX_W-1:0]  reveal_idx;
    logic [CELL_W-1:0] reveal_val;

    modport master (output reveal_valid, reveal_idx, reveal_val, input reveal_ready);
    modport slave  (input reveal_valid, reveal_idx, reveal_val, output reveal_ready);
endinterface

// File: rtl/game_timer.sv
// Saturating elapsed-seconds counter; counts sec_tick pulses while enabled.
module game_timer
    import game_pkg::*;
#(
    parameter  int TIME_MAX = 999,
    localparam int T_W      = clog2(TIME_MAX + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           en,
    input  logic           tick,
    output logic [T_W-1:0] count
);

    localparam logic [T_W-1:0] MAX_CNT = T_W'(TIME_MAX);

    logic [T_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && tick && (count_q < MAX_CNT)) begin
            count_d = count_q + T_W'(1);
        end
    end

    // NOTE: sequential state uses <= so every flop samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/game_status_fsm.sv
// Event-driven Minesweeper game-status tracker: revealed bitmap, safe-cell
// count, IDLE/PLAYING/LOST/WON state machine and elapsed-seconds timer.
module game_status_fsm
    import game_pkg::*;
#(
    parameter  int ROWS      = 8,
    parameter  int COLS      = 8,
    parameter  int NUM_MINES = 10,
    parameter  int CELL_W    = 4,
    parameter  int MINE_CODE = MINE_CODE_DEF,
    parameter  int TIME_MAX  = 999,
    localparam int N         = ROWS * COLS,
    localparam int IDX_W     = clog2(N),
    localparam int CNT_W     = clog2(N + 1),
    localparam int T_W       = clog2(TIME_MAX + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   new_game,
    input  logic                   sec_tick,
    game_status_fsm_if.slave       rev,
    output logic [1:0]             state,
    output logic                   dead,
    output logic                   won,
    output logic [CNT_W-1:0]       revealed_cnt,
    output logic [T_W-1:0]         elapsed_sec,
    output logic                   game_over,
    output logic                   bad_idx
);

    localparam logic [CNT_W-1:0] SAFE_CNT = CNT_W'(N - NUM_MINES);

    game_state_e       state_q, state_d;
    logic [N-1:0]      bitmap_q, bitmap_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              dead_q, dead_d;
    logic              won_q, won_d;
    logic              game_over_q, game_over_d;
    logic              bad_idx_q, bad_idx_d;

    logic [IDX_W-1:0]  idx;
    logic              accept;
    logic              in_range;
    logic              is_mine;

    assign idx              = rev.reveal_idx;
    assign rev.reveal_ready = ((state_q == IDLE) || (state_q == PLAYING)) && !new_game;
    assign accept           = rev.reveal_valid && rev.reveal_ready;
    assign in_range         = int'(idx) < N;
    assign is_mine          = int'(rev.reveal_val) >= MINE_CODE;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        bitmap_d  = bitmap_q;
        cnt_d     = cnt_q;
        bad_idx_d = 1'b0;

        if (new_game) begin
            state_d  = IDLE;
            bitmap_d = '0;
            cnt_d    = '0;
        end else if (accept) begin
            if (!in_range) begin
                bad_idx_d = 1'b1;
            end else if (!bitmap_q[idx]) begin
                bitmap_d[idx] = 1'b1;
                if (is_mine) begin
                    state_d = LOST;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = (cnt_d == SAFE_CNT) ? WON : PLAYING;
                end
            end
        end

        // Status flags are registered copies of the next state; game_over marks the entry edge.
        dead_d      = (state_d == LOST);
        won_d       = (state_d == WON);
        game_over_d = ((state_d == LOST) || (state_d == WON)) && (state_d != state_q);
    end

    // NOTE: the bitmap is a plain flop vector, not a RAM, so clearing it on reset is cheap and safe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bitmap_q    <= '0;
            cnt_q       <= '0;
            dead_q      <= 1'b0;
            won_q       <= 1'b0;
            game_over_q <= 1'b0;
            bad_idx_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitmap_q    <= bitmap_d;
            cnt_q       <= cnt_d;
            dead_q      <= dead_d;
            won_q       <= won_d;
            game_over_q <= game_over_d;
            bad_idx_q   <= bad_idx_d;
        end
    end

    game_timer #(.TIME_MAX(TIME_MAX)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (new_game),
        .en    (state_q == PLAYING),
        .tick  (sec_tick),
        .count (elapsed_sec)
    );

    assign state        = state_q;
    assign dead         = dead_q;
    assign won          = won_q;
    assign revealed_cnt = cnt_q;
    assign game_over    = game_over_q;
    assign bad_idx      = bad_idx_q;

endmodule

// File: tb/tb_game_status_fsm.sv
// Scoreboard bench for game_status_fsm: default 8x8 board (d0) and a 4x5 board (d1).
module tb_game_status_fsm;
    import game_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ng0 = 1'b0, tick0 = 1'b0;
    logic ng1 = 1'b0, tick1 = 1'b0;

    always #5 clk = ~clk;

    game_status_fsm_if #(.IDX_W(6), .CELL_W(4)) if0 ();
    game_status_fsm_if #(.IDX_W(5), .CELL_W(4)) if1 ();

    logic [1:0] d0_state, d1_state;
    logic       d0_dead, d0_won, d0_go, d0_bad;
    logic       d1_dead, d1_won, d1_go, d1_bad;
    logic [6:0] d0_cnt;
    logic [4:0] d1_cnt;
    logic [9:0] d0_el, d1_el;

    game_status_fsm u_d0 (
        .clk(clk), .rst(rst), .new_game(ng0), .sec_tick(tick0), .rev(if0.slave),
        .state(d0_state), .dead(d0_dead), .won(d0_won), .revealed_cnt(d0_cnt),
        .elapsed_sec(d0_el), .game_over(d0_go), .bad_idx(d0_bad)
    );

    game_status_fsm #(.ROWS(4), .COLS(5), .NUM_MINES(3)) u_d1 (
        .clk(clk), .rst(rst), .new_game(ng1), .sec_tick(tick1), .rev(if1.slave),
        .state(d1_state), .dead(d1_dead), .won(d1_won), .revealed_cnt(d1_cnt),
        .elapsed_sec(d1_el), .game_over(d1_go), .bad_idx(d1_bad)
    );

    typedef struct {
        int sel;
        int st;
        int cnt;
        int el;
        int go;
        int bad;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input int expv);
        checks++;
        if (act !== 32'(expv)) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, expv);
        end
    endtask

    // Monitor: one expectation per completed cycle, compared away from the active edge.
    initial begin
        exp_t  e;
        string nm;
        logic [31:0] a_st, a_cnt, a_el, a_dead, a_won, a_go, a_bad, a_rdy;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (e.sel == 0) begin
                    a_st = 32'(d0_state); a_cnt = 32'(d0_cnt); a_el = 32'(d0_el);
                    a_dead = 32'(d0_dead); a_won = 32'(d0_won); a_go = 32'(d0_go);
                    a_bad = 32'(d0_bad); a_rdy = 32'(if0.reveal_ready);
                end else begin
                    a_st = 32'(d1_state); a_cnt = 32'(d1_cnt); a_el = 32'(d1_el);
                    a_dead = 32'(d1_dead); a_won = 32'(d1_won); a_go = 32'(d1_go);
                    a_bad = 32'(d1_bad); a_rdy = 32'(if1.reveal_ready);
                end
                check({nm, ".state"},     a_st,   e.st);
                check({nm, ".cnt"},       a_cnt,  e.cnt);
                check({nm, ".elapsed"},   a_el,   e.el);
                check({nm, ".dead"},      a_dead, (e.st == int'(LOST)) ? 1 : 0);
                check({nm, ".won"},       a_won,  (e.st == int'(WON)) ? 1 : 0);
                check({nm, ".game_over"}, a_go,   e.go);
                check({nm, ".bad_idx"},   a_bad,  e.bad);
                check({nm, ".ready"},     a_rdy,  (e.st <= int'(PLAYING)) ? 1 : 0);
            end
        end
    end

    // Drive one cycle of stimulus on the selected DUT and queue the expected post-edge response.
    task automatic step(input int sel, input bit ng, input bit v, input int idx, input int val,
                        input bit tk, input string nm, input game_state_e e_st, input int e_cnt,
                        input int e_el, input bit e_go, input bit e_bad);
        exp_t e;
        @(negedge clk);
        #1;
        if (sel == 0) begin
            ng0 = ng; tick0 = tk; if0.reveal_valid = v;
            if0.reveal_idx = 6'(idx); if0.reveal_val = 4'(val);
        end else begin
            ng1 = ng; tick1 = tk; if1.reveal_valid = v;
            if1.reveal_idx = 5'(idx); if1.reveal_val = 4'(val);
        end
        @(posedge clk);
        #1;
        ng0 = 1'b0; tick0 = 1'b0; if0.reveal_valid = 1'b0;
        ng1 = 1'b0; tick1 = 1'b0; if1.reveal_valid = 1'b0;
        e.sel = sel; e.st = int'(e_st); e.cnt = e_cnt; e.el = e_el;
        e.go = int'(e_go); e.bad = int'(e_bad);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    initial begin
        if0.reveal_valid = 1'b0; if0.reveal_idx = '0; if0.reveal_val = '0;
        if1.reveal_valid = 1'b0; if1.reveal_idx = '0; if1.reveal_val = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state on both boards.
        step(0, 0, 0, 0, 0, 0, "reset0", IDLE, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, "reset1", IDLE, 0, 0, 0, 0);

        // 54 distinct safe reveals on the default board end in WON.
        for (int i = 0; i < 54; i++)
            step(0, 0, 1, i, i % 9, 0, "win54", (i == 53) ? WON : PLAYING, i + 1, 0, i == 53, 0);
        step(0, 0, 0, 0, 0, 0, "win54_hold", WON, 54, 0, 0, 0);
        step(0, 0, 1, 60, 0, 0, "win54_ignored", WON, 54, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, "ng_after_win", IDLE, 0, 0, 0, 0);

        // Duplicate reveals never count; a mine ends the game and blocks further reveals.
        for (int i = 0; i < 3; i++)
            step(0, 0, 1, 5, 2, 0, "dup5", PLAYING, 1, 0, 0, 0);
        step(0, 0, 1, 6, 9, 0, "mine6", LOST, 1, 0, 1, 0);
        step(0, 0, 1, 7, 0, 0, "after_lost", LOST, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, "ng_after_lost", IDLE, 0, 0, 0, 0);

        // First reveal is a mine: straight to LOST, timer stays 0.
        step(0, 0, 1, 0, 9, 0, "first_mine", LOST, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, "first_mine_tick", LOST, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, "ng_first_mine", IDLE, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, "idle_tick", IDLE, 0, 0, 0, 0);

        // Timer saturation; tick on the IDLE->PLAYING cycle does not count.
        step(0, 0, 1, 0, 0, 1, "start_tick", PLAYING, 1, 0, 0, 0);
        for (int k = 1; k <= 1001; k++)
            step(0, 0, 0, 0, 0, 1, "tick", PLAYING, 1, (k > 999) ? 999 : k, 0, 0);
        step(0, 0, 1, 1, 9, 1, "sat_mine", LOST, 1, 999, 1, 0);
        for (int k = 0; k < 3; k++)
            step(0, 0, 0, 0, 0, 1, "lost_tick", LOST, 1, 999, 0, 0);
        step(0, 1, 0, 0, 0, 0, "ng_sat", IDLE, 0, 0, 0, 0);

        // new_game wins over a same-cycle reveal and clears the bitmap.
        step(0, 0, 1, 2, 1, 0, "play2", PLAYING, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, "play2_tick", PLAYING, 1, 1, 0, 0);
        step(0, 1, 1, 3, 0, 0, "ng_with_reveal", IDLE, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, "ng_settled", IDLE, 0, 0, 0, 0);
        step(0, 0, 1, 2, 1, 0, "bitmap_cleared", PLAYING, 1, 0, 0, 0);

        // 4x5 board: out-of-range index, then 17 safe cells to WON.
        step(1, 0, 1, 25, 0, 0, "bad25", IDLE, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, "bad25_clear", IDLE, 0, 0, 0, 0);
        for (int i = 0; i < 17; i++)
            step(1, 0, 1, i, 1, 0, "win17", (i == 16) ? WON : PLAYING, i + 1, 0, i == 16, 0);
        step(1, 0, 0, 0, 0, 0, "win17_hold", WON, 17, 0, 0, 0);

        repeat (2) @(negedge clk);
        #1;
        check("scoreboard_drain", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
